// File: rtl/bw_logic_unit.sv
// rtl/bw_logic_unit.sv - multi-cycle sliced bitwise logic unit with valid/ready handshakes
//
// Purpose: computes AND/OR/XOR/NOR/NAND/XNOR/ANDN/PASS of two WIDTH-bit
// operands, SLICE bits per clock, so N = WIDTH/SLICE BUSY cycles per op.
// Optional macro BW_FLAGS_EN adds zero / all-ones result flags; when it is
// undefined result_zero and result_ones are tied low.
//
// Ports:
//   clock, reset_n               clock (rising edge), async active-low reset
//   in_valid / in_ready          operand handshake (in_ready = state is IDLE)
//   op, data_operandA/B          operation select and operands
//   out_valid / out_ready        result handshake
//   data_result                  registered result
//   result_zero, result_ones     result flags, meaningful while out_valid

module bw_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             result_zero,
    output logic             result_ones
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_width
            $error("bw_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [KW-1:0]       k_q;
    logic [KW-1:0]       k_d;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [2:0]          op_q;
    logic [WIDTH-1:0]    result_q;
    logic                out_valid_q;

    logic [SLICE-1:0]    a_sl;
    logic [SLICE-1:0]    b_sl;
    logic [SLICE-1:0]    res_sl;

    assign k_d = k_q + KW'(1);

    // Select the current slice with constant part-selects so k only drives a mux.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < N; s++) begin
            if (k_q == KW'(s)) begin
                a_sl = a_q[s*SLICE +: SLICE];
                b_sl = b_q[s*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        res_sl = '0;
        case (op_q)
            3'b000:  res_sl = a_sl & b_sl;
            3'b001:  res_sl = a_sl | b_sl;
            3'b010:  res_sl = a_sl ^ b_sl;
            3'b011:  res_sl = ~(a_sl | b_sl);
            3'b100:  res_sl = ~(a_sl & b_sl);
            3'b101:  res_sl = ~(a_sl ^ b_sl);
            3'b110:  res_sl = a_sl & ~b_sl;
            default: res_sl = a_sl;
        endcase
    end

`ifdef BW_FLAGS_EN
    logic zero_acc_q;
    logic ones_acc_q;
    logic zero_q;
    logic ones_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef BW_FLAGS_EN
            zero_acc_q  <= 1'b0;
            ones_acc_q  <= 1'b0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= data_operandA;
                        b_q     <= data_operandB;
                        op_q    <= op;
                        k_q     <= '0;
                        state_q <= BUSY;
`ifdef BW_FLAGS_EN
                        zero_acc_q <= 1'b1;
                        ones_acc_q <= 1'b1;
`endif
                    end
                end
                BUSY: begin
                    for (int s = 0; s < N; s++) begin
                        if (k_q == KW'(s)) begin
                            result_q[s*SLICE +: SLICE] <= res_sl;
                        end
                    end
`ifdef BW_FLAGS_EN
                    zero_acc_q <= zero_acc_q & (res_sl == '0);
                    ones_acc_q <= ones_acc_q & (res_sl == '1);
`endif
                    if (k_q == K_LAST) begin
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef BW_FLAGS_EN
                        // Fold in the last slice directly; the accumulator lags by one write.
                        zero_q <= zero_acc_q & (res_sl == '0);
                        ones_q <= ones_acc_q & (res_sl == '1);
`endif
                    end else begin
                        k_q <= k_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
`ifdef BW_FLAGS_EN
                        zero_q <= 1'b0;
                        ones_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign data_result = result_q;
`ifdef BW_FLAGS_EN
    assign result_zero = zero_q;
    assign result_ones = ones_q;
`else
    assign result_zero = 1'b0;
    assign result_ones = 1'b0;
`endif

endmodule
